// File: rtl/dm_pkg.sv
// Shared constants, trace record type and byte-enable legality helper for dm_responder.
package dm_pkg;

    localparam int unsigned DM_BASE  = 32'h0000_0000;
    localparam int unsigned DM_LIMIT = 32'h0000_3000;

    localparam int unsigned BE_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    // Legal lane patterns: none, single byte, aligned half, full word.
    function automatic logic is_legal_byteen(input logic [BE_W-1:0] be);
        case (be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: is_legal_byteen = 1'b1;
            default:                   is_legal_byteen = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// Synchronous FIFO for write-trace records; push and pop may coincide even when full.
module trace_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !do_pop;
    assign dout    = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational reads, byte-enabled writes, write-trace FIFO.
// Optional macro DM_ERR_CHECK_EN enables the sticky range/byte-enable error flag.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_LIMIT / 4,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     m_data_addr,
    input  logic [31:0]     m_data_wdata,
    input  logic [BE_W-1:0] m_data_byteen,
    input  logic [31:0]     m_inst_addr,
    output logic [31:0]     m_data_rdata,
    output logic            trace_valid,
    input  logic            trace_ready,
    output logic [31:0]     trace_pc,
    output logic [31:0]     trace_addr,
    output logic [31:0]     trace_data,
    output logic            trace_ovf,
    output logic            range_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned REC_W  = $bits(trace_rec_t);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      cur_word;
    logic [31:0]      merged;
    logic             wr_en;
    trace_rec_t       push_rec;
    trace_rec_t       head_rec;
    logic             fifo_empty;
    logic             fifo_full_unused;
    logic             fifo_ovf;

    assign idx      = m_data_addr[IDX_W+1:2];
    assign in_range = (m_data_addr - 32'(DM_BASE)) < 32'(DEPTH_WORDS * 4);
    assign cur_word = in_range ? mem[idx] : '0;
    assign wr_en    = (m_data_byteen != '0) && in_range;

    assign m_data_rdata = cur_word;

    always_comb begin
        merged = cur_word;
        for (int k = 0; k < BE_W; k++) begin
            if (m_data_byteen[k]) merged[8*k +: 8] = m_data_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[idx] <= merged;
        end
    end

    assign push_rec = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00}, data: merged};

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .din   (push_rec),
        .pop   (trace_ready),
        .dout  (head_rec),
        .empty (fifo_empty),
        .full  (fifo_full_unused),
        .ovf   (fifo_ovf)
    );

    assign trace_valid = !fifo_empty;
    assign trace_pc    = head_rec.pc;
    assign trace_addr  = head_rec.addr;
    assign trace_data  = head_rec.data;

    always_ff @(posedge clk) begin
        if (reset)         trace_ovf <= 1'b0;
        else if (fifo_ovf) trace_ovf <= 1'b1;
    end

`ifdef DM_ERR_CHECK_EN
    logic err_hit;

    assign err_hit = ((m_data_byteen != '0) && !in_range) || !is_legal_byteen(m_data_byteen);

    always_ff @(posedge clk) begin
        if (reset)        range_err <= 1'b0;
        else if (err_hit) range_err <= 1'b1;
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder that sits on the far side of the CPU top's `m_data_*` port, opposite the pipeline's M stage. It serves combinational word reads and applies byte-enabled writes at the clock edge. Every committed write is also pushed as a record `{pc, word address, merged word}` into an internal trace FIFO, which a checker drains over a valid/ready handshake. It is the memory model used in place of the removed in-core data memory.

## Interface
Parameters:
- `DEPTH_WORDS`, 3072: storage words (byte range 0x0000–0x2FFF).
- `FIFO_DEPTH`, 8: trace FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `m_data_addr`  in  32  byte address from the M stage.
- `m_data_wdata`  in  32  write data, already lane-aligned.
- `m_data_byteen`  in  4  byte-lane write enables; 0 means no write.
- `m_inst_addr`  in  32  PC of the M-stage instruction.
- `m_data_rdata`  out  32  read word.
- `trace_valid`  out  1  trace FIFO is non-empty.
- `trace_ready`  in  1  consumer accepts the head record.
- `trace_pc`  out  32  head record PC.
- `trace_addr`  out  32  head record word address (`addr & ~3`).
- `trace_data`  out  32  head record full word after the merge.
- `trace_ovf`  out  1  sticky flag: a record was dropped.
- `range_err`  out  1  sticky access-error flag (see Configuration).

## Operation
- Index is `idx = m_data_addr[13:2]`. The address is in range when `m_data_addr < DEPTH_WORDS*4`.
- Read path:
  - `m_data_rdata = mem[idx]`, combinational, every cycle.
  - An out-of-range address reads 0.
  - A read and a write in the same cycle return the pre-write contents.
- Write path, at the edge when `byteen != 0` and the address is in range:
  - Lane `k` is updated from `wdata[8k+7:8k]` when `byteen[k]` is set.
  - The merged word is pushed to the FIFO.
- An out-of-range write leaves memory unchanged and pushes nothing.
- FIFO push and pop:
  - Pop when `trace_valid && trace_ready`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - A push while full with no pop drops the new record and sets `trace_ovf`. The memory write still happens.
- Reset:
  - All memory words become 0.
  - FIFO pointers and count become 0.
  - `trace_valid=0`, `trace_ovf=0`, `range_err=0`.
  - `m_data_rdata` reads 0 at any in-range address.
  - Reset dominates any write or pop in the same cycle.
- Pointers wrap modulo `FIFO_DEPTH`. The count has `log2(FIFO_DEPTH)+1` bits.

## Timing
- Read latency is 0 cycles (combinational).
- A write issued in cycle N is visible on `m_data_rdata` in cycle N+1.
- The record for a cycle-N write appears at the head no earlier than N+1. `trace_valid` rises at N+1 when the FIFO was empty.
- The head outputs are registered FIFO contents. They remain stable while `trace_valid && !trace_ready`.
- `trace_*` payload outputs are 0 whenever `trace_valid=0`.

## Configuration
- Macro `DM_ERR_CHECK_EN`.
- Defined:
  - `range_err` sets on an out-of-range access with `byteen != 0`.
  - `range_err` also sets on an illegal `byteen` pattern: anything other than `0000`, `0001`, `0010`, `0100`, `1000`, `0011`, `1100`, `1111`.
  - An illegal pattern is still applied to memory as given.
- Undefined: `range_err` is tied to 0 and the checking logic is absent.

## Structure
- Package `dm_pkg` holds:
  - `DM_BASE` = 0 and `DM_LIMIT` = 0x3000.
  - The legal-byteen list.
  - The trace record struct `{pc, addr, data}` (96 bits).
- Sub-module `trace_fifo` is a synchronous FIFO with parameterised width and depth, full/empty and an overflow strobe. The top level holds the storage array, the merge logic and the error checks.

## Test plan
- Reset, then write 0x12345678 to 0x10 with byteen `1111` at PC 0x3000 → `rdata` at 0x10 is 0x12345678 the next cycle; the record is {0x3000, 0x10, 0x12345678}.
- Write `sb` 0xAB000000 with byteen `1000` to 0x13 over the existing 0x12345678 → word 0xAB345678; `trace_addr` is 0x10.
- Nine writes with `trace_ready=0` → `trace_ovf=1` after the ninth; draining returns the first 8 in order; memory holds all 9.
- FIFO full, with a push and `trace_ready=1` in the same cycle → the count stays 8, `trace_ovf` stays 0, and order is preserved.
- Write to 0x3000 with byteen `1111` → no memory change, no record; `range_err=1` only when `DM_ERR_CHECK_EN` is defined.
- Assert `reset` during a write while the FIFO is non-empty → the next cycle has `trace_valid=0`, both flags 0, and `rdata`=0 at the written address.
